// File: rtl/rca_lsq_request_queue_pkg.sv
// Shared configuration and entry type for the grid-to-LSQ request queue.
// Holds the grid geometry, default queue sizes and the buffered request format.
package rca_lsq_request_queue_pkg;

   localparam int XLEN              = 32;
   localparam int GRID_NUM_ROWS     = 4;
   localparam int DEFAULT_DEPTH     = 8;
   localparam int DEFAULT_MAX_LOADS = 4;

   // Wide enough for any practical grid; the tag FIFO keeps only the low bits.
   localparam int ROW_IDX_W = 8;

   typedef struct packed {
      logic [XLEN-1:0]      addr;
      logic [XLEN-1:0]      data;
      logic [2:0]           fn3;
      logic                 load;
      logic                 store;
      logic [ROW_IDX_W-1:0] row;
   } rca_lsq_entry_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rca_lsq_request_queue_rr_arbiter.sv
// Round-robin arbiter: grants the lowest-index requester at or after the pointer.
// The pointer moves past the granted requester only when advance is set.
module rca_rr_arbiter
   import rca_lsq_request_queue_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] request,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PW = idx_width(N);

   logic [PW-1:0] ptr;
   logic [PW-1:0] grant_idx;
   logic          found;

   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && request[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = PW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance && found) begin
         ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + PW'(1);
      end
   end

endmodule

// File: rtl/rca_lsq_request_queue.sv
// Multi-row request queue between the reconfigurable grid and the load-store unit.
// Arbitrates rows into an in-order FIFO and routes in-order load responses back by row tag.
module rca_lsq_request_queue
   import rca_lsq_request_queue_pkg::*;
#(
   parameter int NUM_ROWS    = GRID_NUM_ROWS,
   parameter int DEPTH       = DEFAULT_DEPTH,
   parameter int MAX_LOADS   = DEFAULT_MAX_LOADS,
   parameter int FULL_MARGIN = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic [NUM_ROWS-1:0]      req_valid,
   input  logic [NUM_ROWS-1:0]      req_load,
   input  logic [NUM_ROWS-1:0]      req_store,
   input  logic [NUM_ROWS*XLEN-1:0] req_addr,
   input  logic [NUM_ROWS*XLEN-1:0] req_data,
   input  logic [NUM_ROWS*3-1:0]    req_fn3,
   output logic [NUM_ROWS-1:0]      req_accept,
   output logic                     fifo_full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ls_valid,
   input  logic                     ls_ready,
   output logic [XLEN-1:0]          ls_addr,
   output logic [XLEN-1:0]          ls_data,
   output logic [2:0]               ls_fn3,
   output logic                     ls_load,
   output logic                     ls_store,
   input  logic                     ls_rsp_valid,
   input  logic [XLEN-1:0]          ls_rsp_data,
   output logic [NUM_ROWS-1:0]      load_complete,
   output logic [XLEN-1:0]          load_data,
   output logic                     rsp_error
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int TAW   = $clog2(MAX_LOADS);
   localparam int TCW   = TAW + 1;
   localparam int TAG_W = idx_width(NUM_ROWS);

   rca_lsq_entry_t        mem [DEPTH];
   rca_lsq_entry_t        head;
   rca_lsq_entry_t        wr_entry;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count_next;
   logic [NUM_ROWS-1:0]   arb_request;
   logic [NUM_ROWS-1:0]   grant;
   logic                  enq_enable;
   logic                  push;
   logic                  pop;
   logic                  empty;

   logic [TAG_W-1:0]      tag_mem [MAX_LOADS];
   logic [TAG_W-1:0]      tag_head;
   logic [TAW-1:0]        tag_wr;
   logic [TAW-1:0]        tag_rd;
   logic [TCW-1:0]        tag_count;
   logic                  tag_full;
   logic                  tag_empty;
   logic                  tag_push;
   logic                  tag_pop;
   logic [NUM_ROWS-1:0]   tag_onehot;

   // A full queue or a flush masks every row before arbitration, so the pointer only moves on real grants.
   assign enq_enable  = rst_n && !flush && (count != CW'(DEPTH));
   assign arb_request = enq_enable ? req_valid : '0;

   rca_rr_arbiter #(
      .N(NUM_ROWS)
   ) u_arbiter (
      .clk     (clk),
      .rst_n   (rst_n),
      .request (arb_request),
      .advance (enq_enable),
      .grant   (grant)
   );

   assign req_accept = grant;
   assign push       = |grant;

   always_comb begin
      wr_entry = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         if (grant[i]) begin
            wr_entry.addr  = req_addr[i*XLEN +: XLEN];
            wr_entry.data  = req_data[i*XLEN +: XLEN];
            wr_entry.fn3   = req_fn3[i*3 +: 3];
            wr_entry.store = req_store[i];
            wr_entry.load  = req_load[i] & ~req_store[i];
            wr_entry.row   = ROW_IDX_W'(i);
         end
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

   // Valid is withheld during flush so the LSU never sees a handshake on an entry being discarded.
   assign ls_valid = rst_n && !flush && !empty && (head.store || !tag_full);
   assign pop      = ls_valid && ls_ready;
   assign ls_addr  = head.addr;
   assign ls_data  = head.data;
   assign ls_fn3   = head.fn3;
   assign ls_load  = head.load;
   assign ls_store = head.store;

   always_comb begin
      count_next = count;
      if (flush) begin
         count_next = '0;
      end else if (push && !pop) begin
         count_next = count + CW'(1);
      end else if (pop && !push) begin
         count_next = count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         fifo_full <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end
         count     <= count_next;
         fifo_full <= (count_next >= CW'(DEPTH - FULL_MARGIN));
      end
   end

   assign tag_head  = tag_mem[tag_rd];
   assign tag_full  = (tag_count == TCW'(MAX_LOADS));
   assign tag_empty = (tag_count == '0);
   assign tag_push  = pop && head.load;
   assign tag_pop   = ls_rsp_valid && !tag_empty;

   always_comb begin
      tag_onehot = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         if (int'(tag_head) == i) tag_onehot[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_push) begin
         tag_mem[tag_wr] <= TAG_W'(head.row);
      end
   end

   // Responses return in issue order, so popping the tag FIFO identifies the requesting row.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_wr        <= '0;
         tag_rd        <= '0;
         tag_count     <= '0;
         load_complete <= '0;
         load_data     <= '0;
         rsp_error     <= 1'b0;
      end else begin
         if (tag_push) tag_wr <= tag_wr + TAW'(1);
         if (tag_pop)  tag_rd <= tag_rd + TAW'(1);
         case ({tag_push, tag_pop})
            2'b10:   tag_count <= tag_count + TCW'(1);
            2'b01:   tag_count <= tag_count - TCW'(1);
            default: tag_count <= tag_count;
         endcase
         load_complete <= tag_pop ? tag_onehot : '0;
         if (tag_pop) load_data <= ls_rsp_data;
         if (ls_rsp_valid && tag_empty) rsp_error <= 1'b1;
      end
   end

endmodule

// File: doc/rca_lsq_request_queue.md
Name: rca_lsq_request_queue

Overview:
- Parametrised successor to the single-port grid-to-LSQ link.
- Accepts load/store requests from NUM_ROWS reconfigurable-grid rows, selecting one row per cycle by round-robin, and buffers them in an in-order request FIFO.
- Issues requests to the load-store unit over a valid/ready handshake.
- Tracks outstanding loads so that each in-order load response is returned to the row that issued it.

Parameters:
NUM_ROWS, 4 (GRID_NUM_ROWS), number of grid rows that can issue requests
DEPTH, 8, request FIFO entries (power of two)
MAX_LOADS, 4, outstanding-load tag FIFO entries (power of two)
FULL_MARGIN, 1, fifo_full asserts when count >= DEPTH-FULL_MARGIN

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
flush  in  1  drop all queued (unissued) requests
req_valid  in  NUM_ROWS  per-row request pending; held until accepted
req_load  in  NUM_ROWS  per-row load flag
req_store  in  NUM_ROWS  per-row store flag
req_addr  in  NUM_ROWS*XLEN  per-row address, offset already applied
req_data  in  NUM_ROWS*XLEN  per-row store data
req_fn3  in  NUM_ROWS*3  per-row access size/sign
req_accept  out  NUM_ROWS  one-hot; the row's request is enqueued this cycle
fifo_full  out  1  backpressure to grid control
count  out  $clog2(DEPTH)+1  request FIFO occupancy
ls_valid  out  1  head request presented to the load-store unit
ls_ready  in  1  load-store unit accepts the head request
ls_addr  out  XLEN  head address
ls_data  out  XLEN  head store data
ls_fn3  out  3  head fn3
ls_load  out  1  head is a load
ls_store  out  1  head is a store
ls_rsp_valid  in  1  in-order load response
ls_rsp_data  in  XLEN  load response data
load_complete  out  NUM_ROWS  one-hot, single-cycle pulse per returned load
load_data  out  XLEN  data qualified by load_complete
rsp_error  out  1  sticky: a response arrived with no outstanding load

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - count, both FIFO pointers, arbiter pointer (row 0 highest priority), load_complete, load_data and rsp_error all go to 0.
  - ls_valid=0, req_accept=0, fifo_full=0.
  - A reset during an outstanding transaction discards all state.
- Enqueue (combinational grant):
  - The arbiter grants the lowest-index valid row at or after the round-robin pointer.
  - The grant is suppressed when count==DEPTH or flush=1.
  - On a grant, the pointer moves to (granted row+1) mod NUM_ROWS.
  - The entry is written at the clk edge and is visible at the head on the next cycle; there is no bypass.
- A row asserting both req_load and req_store is treated as a store.
- Issue:
  - ls_valid = !empty && (head is store || tag FIFO not full).
  - Head fields are driven combinationally from the FIFO head.
  - A transfer occurs when ls_valid && ls_ready; the head is popped, and for a load the head's row index is pushed into the tag FIFO in the same edge.
  - A transfer is not allowed to complete in the same cycle as flush.
- Occupancy:
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - fifo_full is registered from next count.
- Response:
  - On ls_rsp_valid, the tag FIFO is popped.
  - One cycle later, load_complete[tag] pulses for exactly one cycle with load_data = ls_rsp_data.
  - Back-to-back responses produce back-to-back pulses.
  - A response with an empty tag FIFO is dropped and sets rsp_error until reset.
- Flush:
  - Clears the request FIFO (count=0) at the edge.
  - Outstanding loads in the tag FIFO are unaffected; their responses are still delivered.
  - A flush coinciding with an enqueue: the enqueue is not granted.
- Simultaneous tag push and pop are both performed.
- Widths: count is $clog2(DEPTH)+1 bits; tag FIFO entries are $clog2(NUM_ROWS) bits (minimum 1).

Decomposition:
- rca_config holds GRID_NUM_ROWS and the defaults for DEPTH and MAX_LOADS.
- A shared package adds the typedef rca_lsq_entry_t {addr, data, fn3, load, store, row}.
- One natural sub-module, rca_rr_arbiter: parameter N; inputs request[N] and advance; output grant one-hot.
- Both FIFOs reuse the existing taiga FIFO structure.

Test Plan:
- Reset then idle: rows 0-3 idle → ls_valid=0, count=0, fifo_full=0, load_complete=0 for 5 cycles.
- Fairness: all 4 rows hold loads, ls_ready=1 → grants rows 0,1,2,3,0 on consecutive cycles; ls_valid rises the cycle after the first grant.
- Fill/backpressure: ls_ready=0, row 2 issues 8 stores → count reaches 8; fifo_full=1 from count 7 (margin 1); 9th request not accepted; with ls_ready=1 the store drains 1 per cycle.
- Load routing: loads from rows 3,1 (addr 0x100, 0x104); responses 0xAAAA then 0xBBBB → load_complete=0b1000 with 0xAAAA, then 0b0010 with 0xBBBB, each one cycle after ls_rsp_valid.
- Tag stall: MAX_LOADS=4 loads issued with no responses, 5th load at head → ls_valid=0; a store behind it does not bypass; one response → ls_valid=1 next cycle.
- Flush and error: 3 queued requests plus 1 outstanding load, flush=1 → count=0 next cycle and the load response is still returned. Extra ls_rsp_valid with no outstanding load → rsp_error=1 until rst_n=0.
